// File: rtl/prog_delay_fsm.sv
// prog_delay_fsm
//   Programmable delay timer. A start request in IDLE latches the delay value
//   into the target register and enters WAIT. The cycle counter then runs from
//   0 up to the target. One cycle later the FSM reaches DONE, and the event
//   counter is bumped. From DONE it returns to IDLE (one-shot mode) or
//   re-enters WAIT with a freshly latched delay (auto_restart mode). An abort
//   in WAIT or DONE returns to IDLE and produces a one-cycle aborted pulse.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-high reset
//   start         in   begin a timed wait (sampled in IDLE only)
//   abort         in   cancel the wait (sampled in WAIT and DONE)
//   auto_restart  in   1 = periodic operation, 0 = one-shot
//   delay         in   wait target, latched on every entry into WAIT
//   busy          out  high while in WAIT
//   done          out  high for the single DONE cycle
//   aborted       out  one-cycle pulse after an accepted abort
//   count         out  cycle counter (0 outside WAIT)
//   evt_cnt       out  DONE entries since reset, wrapping
//
// state | meaning
// IDLE  | waiting for start
// WAIT  | counting cycles up to the latched target
// DONE  | one-cycle completion, then restart or return to IDLE
module prog_delay_fsm #(
  parameter int CNT_W = 8,
  parameter int EVT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             auto_restart,
  input  logic [CNT_W-1:0] delay,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] count,
  output logic [EVT_W-1:0] evt_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] target_q,  target_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic             aborted_q, aborted_d;

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    count_d   = count_q;
    evt_cnt_d = evt_cnt_q;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        // abort has priority over a simultaneous start
        if (start && !abort) begin
          state_d  = WAIT;
          target_d = delay;
        end
      end
      WAIT: begin
        if (abort) begin
          state_d   = IDLE;
          count_d   = '0;
          aborted_d = 1'b1;
        end else if (count_q == target_q) begin
          // stopping on equality keeps the counter from ever wrapping,
          // even with the maximum target
          state_d   = DONE;
          count_d   = '0;
          evt_cnt_d = evt_cnt_q + EVT_W'(1);
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      DONE: begin
        count_d = '0;
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (auto_restart) begin
          state_d  = WAIT;
          target_d = delay;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        // unused encoding 2'b11 recovers to IDLE
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      target_q  <= '0;
      count_q   <= '0;
      evt_cnt_q <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      count_q   <= count_d;
      evt_cnt_q <= evt_cnt_d;
      aborted_q <= aborted_d;
    end
  end

  assign busy    = (state_q == WAIT);
  assign done    = (state_q == DONE);
  assign aborted = aborted_q;
  assign count   = count_q;
  assign evt_cnt = evt_cnt_q;

endmodule

// File: tb/tb_prog_delay_fsm.sv
module tb_prog_delay_fsm;
  localparam int CNT_W = 8;
  localparam int EVT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             auto_restart = 1'b0;
  logic [CNT_W-1:0] delay = '0;
  logic             busy, done, aborted;
  logic [CNT_W-1:0] count;
  logic [EVT_W-1:0] evt_cnt;

  int vectors = 0;
  int miscompares = 0;

  prog_delay_fsm #(.CNT_W(CNT_W), .EVT_W(EVT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .auto_restart(auto_restart), .delay(delay), .busy(busy), .done(done),
    .aborted(aborted), .count(count), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  // advance one rising edge and settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({busy, done, aborted} !== 3'b000) begin
      $display("FAIL reset_flags busy/done/aborted got %b want 000", {busy, done, aborted});
      miscompares++;
    end
    vectors++;
    if (count !== 8'd0 || evt_cnt !== 4'd0) begin
      $display("FAIL reset_counts count=%0d evt=%0d want 0/0", count, evt_cnt);
      miscompares++;
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_one_shot(input logic [EVT_W-1:0] exp_evt);
    delay = 8'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0 || count !== 8'(i)) begin
        $display("FAIL one_shot_wait step %0d busy=%b done=%b count=%0d want 1/0/%0d",
                 i, busy, done, count, i);
        miscompares++;
      end
      tick();
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || evt_cnt !== exp_evt) begin
      $display("FAIL one_shot_done done=%b busy=%b evt=%0d want 1/0/%0d",
               done, busy, evt_cnt, exp_evt);
      miscompares++;
    end
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || count !== 8'd0) begin
      $display("FAIL one_shot_idle done=%b busy=%b count=%0d want 0/0/0", done, busy, count);
      miscompares++;
    end
  endtask

  task automatic test_zero_delay();
    delay = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0 || count !== 8'd0) begin
      $display("FAIL zero_wait busy=%b done=%b count=%0d want 1/0/0", busy, done, count);
      miscompares++;
    end
    tick();
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || evt_cnt !== 4'd2) begin
      $display("FAIL zero_done done=%b busy=%b evt=%0d want 1/0/2", done, busy, evt_cnt);
      miscompares++;
    end
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL zero_idle done=%b busy=%b want 0/0", done, busy);
      miscompares++;
    end
  endtask

  task automatic test_abort();
    delay = 8'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    vectors++;
    if (count !== 8'd2 || busy !== 1'b1) begin
      $display("FAIL abort_pre count=%0d busy=%b want 2/1", count, busy);
      miscompares++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b1 || count !== 8'd0 || evt_cnt !== 4'd2) begin
      $display("FAIL abort_wait busy=%b done=%b aborted=%b count=%0d evt=%0d want 0/0/1/0/2",
               busy, done, aborted, count, evt_cnt);
      miscompares++;
    end
    tick();
    vectors++;
    if (aborted !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL abort_pulse_end aborted=%b done=%b busy=%b want 0/0/0", aborted, done, busy);
      miscompares++;
    end
    // start and abort together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || aborted !== 1'b0 || done !== 1'b0) begin
      $display("FAIL abort_idle busy=%b aborted=%b done=%b want 0/0/0", busy, aborted, done);
      miscompares++;
    end
    // abort in DONE: event already counted, restart suppressed
    auto_restart = 1'b1;
    delay = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    vectors++;
    if (done !== 1'b1 || evt_cnt !== 4'd3) begin
      $display("FAIL abort_done_pre done=%b evt=%0d want 1/3", done, evt_cnt);
      miscompares++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    auto_restart = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b1 || evt_cnt !== 4'd3) begin
      $display("FAIL abort_done busy=%b done=%b aborted=%b evt=%0d want 0/0/1/3",
               busy, done, aborted, evt_cnt);
      miscompares++;
    end
    tick();
  endtask

  // ticks until done is seen, bounded by lim
  task automatic wait_done(input int lim, output int n, output logic [CNT_W-1:0] last_count);
    n = 0;
    last_count = count;
    do begin
      last_count = count;
      tick();
      n++;
    end while (done !== 1'b1 && n < lim);
  endtask

  task automatic test_periodic();
    int n;
    logic [CNT_W-1:0] lc;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    auto_restart = 1'b1;
    delay = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      wait_done(20, n, lc);
      vectors++;
      if (n !== ((k == 1) ? 4 : 5)) begin
        $display("FAIL periodic_gap completion %0d took %0d clocks want %0d",
                 k, n, (k == 1) ? 4 : 5);
        miscompares++;
      end
    end
    vectors++;
    if (evt_cnt !== 4'd1) begin
      $display("FAIL periodic_wrap evt=%0d want 1", evt_cnt);
      miscompares++;
    end
    tick();
    auto_restart = 1'b0;
    wait_done(20, n, lc);
    vectors++;
    if (n !== 4 || evt_cnt !== 4'd2) begin
      $display("FAIL periodic_last clocks=%0d evt=%0d want 4/2", n, evt_cnt);
      miscompares++;
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL periodic_stop busy=%b done=%b want 0/0", busy, done);
      miscompares++;
    end
  endtask

  task automatic test_boundary();
    int n;
    logic [CNT_W-1:0] lc;
    delay = 8'd255;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    delay = 8'd2;
    wait_done(300, n, lc);
    vectors++;
    if (n !== 246 || lc !== 8'd255) begin
      $display("FAIL boundary_latency clocks_after_change=%0d last_count=%0d want 246/255", n, lc);
      miscompares++;
    end
    vectors++;
    if (evt_cnt !== 4'd3 || count !== 8'd0) begin
      $display("FAIL boundary_done evt=%0d count=%0d want 3/0", evt_cnt, count);
      miscompares++;
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    bit spurious;
    delay = 8'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    vectors++;
    if (count !== 8'd3) begin
      $display("FAIL rstmid_pre count=%0d want 3", count);
      miscompares++;
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({busy, done, aborted} !== 3'b000 || count !== 8'd0 || evt_cnt !== 4'd0) begin
      $display("FAIL rstmid_async flags=%b count=%0d evt=%0d want 000/0/0",
               {busy, done, aborted}, count, evt_cnt);
      miscompares++;
    end
    tick();
    tick();
    rst = 1'b0;
    spurious = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
    end
    vectors++;
    if (spurious) begin
      $display("FAIL rstmid_spurious activity after release got 1 want 0");
      miscompares++;
    end
    test_one_shot(4'd1);
  endtask

  initial begin
    test_reset();
    test_one_shot(4'd1);
    test_zero_delay();
    test_abort();
    test_periodic();
    test_boundary();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
